// File: rtl/mp_mem_arbiter.sv
// Four-core round-robin arbiter and single-beat transaction sequencer for the
// shared memory port; returns read data (or a timeout error) to the granted core.
module mp_mem_arbiter #(
  parameter int unsigned NUM_CORES      = 4,
  parameter int unsigned ADDR_WIDTH     = 11,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_CORES-1:0]             core_req,
  input  logic [NUM_CORES-1:0]             core_we,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0]  core_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_data_in,
  input  logic [NUM_CORES*4-1:0]           core_opcode,
  output logic [NUM_CORES-1:0]             core_gnt,
  output logic [NUM_CORES-1:0]             core_rvalid,
  output logic [DATA_WIDTH-1:0]            core_rdata,
  output logic                             core_err,
  output logic                             mem_read_en,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_data_in,
  output logic [1:0]                       mem_core_id,
  output logic [3:0]                       mem_opcode,
  input  logic [DATA_WIDTH-1:0]            mem_data_out,
  input  logic                             mem_rvalid
);

  localparam int unsigned   CW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LP_TIMEOUT = CW'(TIMEOUT_CYCLES);
  localparam logic [1:0]    LP_LAST    = 2'(NUM_CORES - 1);
  localparam logic [2:0]    LP_NCORES  = 3'(NUM_CORES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [1:0]              r_ptr;
  logic [1:0]              r_sel;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [3:0]              r_opcode;
  logic [CW-1:0]           r_cnt;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic [CW-1:0]           w_cnt_next;
  logic                    w_timeout;
  logic                    w_found;
  logic [1:0]              w_pick;
  logic [2:0]              w_sum;
  logic [NUM_CORES-1:0]    w_sel_oh;

  logic [ADDR_WIDTH-1:0]   w_addr_arr [NUM_CORES];
  logic [DATA_WIDTH-1:0]   w_data_arr [NUM_CORES];
  logic [3:0]              w_op_arr   [NUM_CORES];

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
    assign w_addr_arr[gi] = core_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data_arr[gi] = core_data_in[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_op_arr[gi]   = core_opcode[gi*4 +: 4];
  end

  // First requester at or after the pointer, wrapping modulo NUM_CORES.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      w_sum = {1'b0, r_ptr} + 3'(k);
      if (w_sum >= LP_NCORES) begin
        w_sum = w_sum - LP_NCORES;
      end
      if (!w_found && core_req[w_sum[1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[1:0];
      end
    end
  end

  assign w_cnt_next = r_cnt + 1'b1;
  assign w_timeout  = (w_cnt_next == LP_TIMEOUT);

  always_comb begin
    w_sel_oh        = '0;
    w_sel_oh[r_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_next = ISSUE;
      ISSUE:   w_state_next = r_we ? IDLE : WAIT_RD;
      WAIT_RD: if (mem_rvalid || w_timeout) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs decode only registered state, so no input reaches an output combinationally.
  always_comb begin
    core_gnt    = '0;
    core_rvalid = '0;
    core_rdata  = '0;
    core_err    = 1'b0;
    mem_we      = 1'b0;
    mem_read_en = 1'b0;
    mem_addr    = r_addr;
    mem_data_in = r_data;
    mem_core_id = r_sel;
    mem_opcode  = r_opcode;
    case (r_state)
      ISSUE: begin
        core_gnt    = w_sel_oh;
        mem_we      = r_we;
        mem_read_en = !r_we;
      end
      RESP: begin
        core_rvalid = w_sel_oh;
        core_rdata  = r_rdata;
        core_err    = r_err;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr    <= '0;
      r_sel    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_opcode <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_sel    <= w_pick;
            r_we     <= core_we[w_pick];
            r_addr   <= w_addr_arr[w_pick];
            r_data   <= w_data_arr[w_pick];
            r_opcode <= w_op_arr[w_pick];
          end
        end
        ISSUE: begin
          r_ptr <= (r_sel == LP_LAST) ? '0 : r_sel + 1'b1;
          r_cnt <= '0;
          r_err <= 1'b0;
        end
        WAIT_RD: begin
          r_cnt <= w_cnt_next;
          // Data arriving on the limit cycle takes priority over the timeout.
          if (mem_rvalid) begin
            r_rdata <= mem_data_out;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end
        end
        RESP: begin
          r_cnt <= '0;
          r_err <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_mem_arbiter.sv
// Scoreboard bench for mp_mem_arbiter: stimulus queues hand-computed grant and
// read-return events; a negedge monitor pops and checks them as the DUT emits them.
module tb_mp_mem_arbiter;

  localparam int NC = 4;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [NC-1:0]     core_req = '0;
  logic [NC-1:0]     core_we = '0;
  logic [NC*AW-1:0]  core_addr = '0;
  logic [NC*DW-1:0]  core_data_in = '0;
  logic [NC*4-1:0]   core_opcode = '0;
  logic [NC-1:0]     core_gnt;
  logic [NC-1:0]     core_rvalid;
  logic [DW-1:0]     core_rdata;
  logic              core_err;
  logic              mem_read_en;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_data_in;
  logic [1:0]        mem_core_id;
  logic [3:0]        mem_opcode;
  logic [DW-1:0]     mem_data_out = '0;
  logic              mem_rvalid = 1'b0;

  mp_mem_arbiter #(
    .NUM_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_data_in(core_data_in), .core_opcode(core_opcode),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .core_err(core_err), .mem_read_en(mem_read_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_core_id(mem_core_id),
    .mem_opcode(mem_opcode), .mem_data_out(mem_data_out), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    bit            is_gnt;
    logic [NC-1:0] vec;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    id;
    logic [3:0]    op;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [63:0] all_outs();
    return {20'd0, core_gnt, core_rvalid, core_rdata, core_err, mem_read_en,
            mem_we, mem_addr, mem_data_in, mem_core_id, mem_opcode};
  endfunction

  task automatic check_vec(input string name, input logic [63:0] got, input logic [63:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (core_gnt != '0 || core_rvalid != '0) begin
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event cyc=%0d: got gnt=%b rvalid=%b, required none",
                 cyc, core_gnt, core_rvalid);
      end else begin
        e = sb.pop_front();
        vectors++;
        if (e.is_gnt) begin
          if (cyc !== e.cyc || core_gnt !== e.vec || mem_we !== e.we ||
              mem_read_en !== !e.we || mem_addr !== e.addr || mem_data_in !== e.data ||
              mem_core_id !== e.id || mem_opcode !== e.op || core_rvalid !== '0) begin
            miscompares++;
            $display("FAIL grant: got cyc=%0d gnt=%b we=%b re=%b addr=%h din=%h id=%0d op=%h; required cyc=%0d gnt=%b we=%b re=%b addr=%h din=%h id=%0d op=%h",
                     cyc, core_gnt, mem_we, mem_read_en, mem_addr, mem_data_in, mem_core_id, mem_opcode,
                     e.cyc, e.vec, e.we, !e.we, e.addr, e.data, e.id, e.op);
          end
        end else begin
          if (cyc !== e.cyc || core_rvalid !== e.vec || core_rdata !== e.data ||
              core_err !== e.err || core_gnt !== '0) begin
            miscompares++;
            $display("FAIL rvalid: got cyc=%0d rvalid=%b rdata=%h err=%b; required cyc=%0d rvalid=%b rdata=%h err=%b",
                     cyc, core_rvalid, core_rdata, core_err, e.cyc, e.vec, e.data, e.err);
          end
        end
      end
    end else if (mem_we || mem_read_en || core_err) begin
      miscompares++;
      $display("FAIL stray_strobe cyc=%0d: got we=%b re=%b err=%b, required 0",
               cyc, mem_we, mem_read_en, core_err);
    end
  end

  task automatic set_core(input int c, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [3:0] op);
    core_req[c]           = 1'b1;
    core_we[c]            = we;
    core_addr[c*AW +: AW] = a;
    core_data_in[c*DW +: DW] = d;
    core_opcode[c*4 +: 4] = op;
  endtask

  task automatic push_gnt(input int at, input int c, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [3:0] op);
    exp_t e;
    e.cyc = at; e.is_gnt = 1'b1; e.vec = NC'(1 << c); e.we = we; e.addr = a;
    e.data = d; e.id = 2'(c); e.op = op; e.err = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_rv(input int at, input int c, input logic [DW-1:0] d, input logic err);
    exp_t e;
    e.cyc = at; e.is_gnt = 1'b0; e.vec = NC'(1 << c); e.we = 1'b0; e.addr = '0;
    e.data = d; e.id = 2'(c); e.op = '0; e.err = err;
    sb.push_back(e);
  endtask

  // Called on a negedge with the DUT idle; returns on a negedge with the DUT idle.
  task automatic do_write(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [3:0] op);
    int c0;
    c0 = cyc;
    set_core(c, 1'b1, a, d, op);
    push_gnt(c0 + 1, c, 1'b1, a, d, op);
    @(negedge clk);
    core_req[c] = 1'b0;
    @(negedge clk);
  endtask

  // n = 0: memory never answers (timeout), followed by a stray mem_rvalid.
  task automatic do_read(input int c, input logic [AW-1:0] a, input logic [3:0] op,
                         input int n, input logic [DW-1:0] d);
    int s;
    s = cyc + 1;
    set_core(c, 1'b0, a, 8'h00, op);
    push_gnt(s, c, 1'b0, a, 8'h00, op);
    @(negedge clk);
    core_req[c] = 1'b0;
    if (n > 0) begin
      while (cyc < s + n) @(negedge clk);
      mem_rvalid   = 1'b1;
      mem_data_out = d;
      push_rv(s + n + 1, c, d, 1'b0);
      @(negedge clk);
      mem_rvalid   = 1'b0;
      mem_data_out = '0;
      @(negedge clk);
    end else begin
      push_rv(s + TO + 1, c, 8'h00, 1'b1);
      while (cyc < s + TO + 1) @(negedge clk);
      mem_rvalid   = 1'b1;
      mem_data_out = 8'hEE;
      @(negedge clk);
      @(negedge clk);
      mem_rvalid   = 1'b0;
      mem_data_out = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_vec("reset_outputs", all_outs(), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a read from core 2.
    c0 = cyc;
    set_core(2, 1'b0, 11'h155, 8'h00, 4'h9);
    push_gnt(c0 + 1, 2, 1'b0, 11'h155, 8'h00, 4'h9);
    @(negedge clk);
    core_req[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_vec("wait_rd_hold", all_outs(), {20'd0, 4'b0, 4'b0, 8'h00, 1'b0, 1'b0, 1'b0,
                                           11'h155, 8'h00, 2'd2, 4'h9});
    #2 reset_n = 1'b0;
    #1 check_vec("async_reset_outputs", all_outs(), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_data_out = 8'h5A;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_data_out = '0;
    @(negedge clk);

    // Pointer must be back at 0: core 1 wins over core 3.
    c0 = cyc;
    set_core(1, 1'b1, 11'h0AA, 8'h11, 4'h1);
    set_core(3, 1'b1, 11'h0BB, 8'h33, 4'h2);
    push_gnt(c0 + 1, 1, 1'b1, 11'h0AA, 8'h11, 4'h1);
    push_gnt(c0 + 3, 3, 1'b1, 11'h0BB, 8'h33, 4'h2);
    @(negedge clk);
    core_req[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    core_req[3] = 1'b0;
    @(negedge clk);

    do_write(1, 11'h7FF, 8'hA5, 4'h3);
    do_read(3, 11'h010, 4'h5, 2, 8'h3C);

    // All four cores writing continuously, pointer at 0.
    c0 = cyc;
    for (int i = 0; i < NC; i++)
      set_core(i, 1'b1, AW'(11'h100 + i), DW'(8'hC0 + i), 4'(4 + i));
    for (int k = 0; k < 6; k++)
      push_gnt(c0 + 1 + 2*k, k % NC, 1'b1, AW'(11'h100 + (k % NC)),
               DW'(8'hC0 + (k % NC)), 4'(4 + (k % NC)));
    while (cyc < c0 + 11) @(negedge clk);
    core_req = '0;
    @(negedge clk);

    do_read(0, 11'h2A0, 4'hE, 0, 8'h00);
    do_read(2, 11'h333, 4'h7, TO, 8'h77);
    do_read(1, 11'h444, 4'h2, 1, 8'hC3);

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares += sb.size();
      $display("FAIL pending_events: got %0d unmatched, required 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mp_mem_arbiter.md
Name: mp_mem_arbiter

Overview:
- Four-core round-robin arbiter and transaction sequencer in front of the shared memory of the multiprocessor system.
- Each core presents a request (req, we, addr, data_in, opcode). The block grants one core at a time and issues a single-beat read or write on the shared memory port (read_en, we, addr, data_in, core_id, opcode).
- It then returns read data to the granted core with a per-core valid strobe.
- A read that gets no memory response is terminated by a timeout with an error flag.

Parameters:
- NUM_CORES, 4, number of requesting cores; core_id width is fixed at 2, so this must not exceed 4.
- ADDR_WIDTH, 11, memory address width.
- DATA_WIDTH, 8, memory data width.
- TIMEOUT_CYCLES, 16, maximum cycles to wait for mem_rvalid after a read is issued; must be at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- core_req  input  NUM_CORES  per-core request, level, held until granted.
- core_we  input  NUM_CORES  per-core write enable (1 = write, 0 = read).
- core_addr  input  NUM_CORES*ADDR_WIDTH  packed per-core address; core i occupies slice i.
- core_data_in  input  NUM_CORES*DATA_WIDTH  packed per-core write data.
- core_opcode  input  NUM_CORES*4  packed per-core opcode, passed through unmodified.
- core_gnt  output  NUM_CORES  one-hot grant, single-cycle pulse.
- core_rvalid  output  NUM_CORES  one-hot read-return strobe, single-cycle pulse.
- core_rdata  output  DATA_WIDTH  read return data, valid only while a core_rvalid bit is high.
- core_err  output  1  high together with core_rvalid when the read timed out.
- mem_read_en  output  1  memory read strobe.
- mem_we  output  1  memory write strobe.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_data_in  output  DATA_WIDTH  memory write data.
- mem_core_id  output  2  index of the granted core.
- mem_opcode  output  4  opcode of the granted core.
- mem_data_out  input  DATA_WIDTH  memory read data.
- mem_rvalid  input  1  memory read data valid.

Behaviour:
- Reset (async assert, sync release):
  - All outputs go to 0. FSM goes to IDLE. Round-robin pointer goes to 0. Timeout counter is cleared.
  - An in-flight transaction is abandoned; no rvalid is produced for it after reset releases.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - If any core_req is high, select the first requesting core at or after the pointer, wrapping modulo NUM_CORES.
  - Latch that core's we, addr, data_in and opcode. Go to ISSUE.
- ISSUE (exactly one cycle):
  - core_gnt[sel] = 1.
  - mem_core_id = sel; mem_opcode, mem_addr and mem_data_in are driven from the latched values.
  - mem_we = latched we; mem_read_en = !latched we.
  - Pointer updates to sel+1 (mod NUM_CORES).
  - Write: next state is IDLE. Read: next state is WAIT_RD.
- WAIT_RD:
  - All mem strobes are 0. mem_addr, mem_core_id and mem_opcode hold their values.
  - The counter increments each cycle.
  - On mem_rvalid: capture mem_data_out into core_rdata and go to RESP.
  - If the counter reaches TIMEOUT_CYCLES without mem_rvalid: core_rdata = 0, set the error flag, go to RESP.
  - If mem_rvalid arrives in the same cycle the count reaches the limit, the data wins and there is no error.
- RESP (one cycle):
  - core_rvalid[sel] = 1; core_err = timeout flag.
  - Then go to IDLE and clear the counter and flag.
- Latency:
  - Request seen in IDLE → gnt and mem strobe at cycle +1.
  - Read with mem_rvalid N cycles after the strobe (N ≥ 1) → core_rvalid N+1 cycles after the strobe.
  - A write has a 2-cycle occupancy, so back-to-back writes from different cores reach the memory every 2 cycles.
- A mem_rvalid seen in IDLE, ISSUE or RESP is ignored.
- A request withdrawn before grant is not serviced. Requests are not queued; arbitration re-evaluates in every IDLE cycle.
- Fairness: with all cores requesting continuously, grants cycle 0,1,2,3,0…; no core waits more than NUM_CORES grants.
- mem_rvalid and mem_data_out are sampled on the clock edge; there is no combinational path from any input to any output.

Test Plan:
- Reset mid-read: core 2 reads addr 0x155, assert reset_n low during WAIT_RD → all outputs 0 immediately, IDLE after release, no core_rvalid, pointer = 0.
- Single write: core1 write addr 0x7FF, data 0xA5, opcode 0x3 → core_gnt = 0010 and mem_we = 1 with mem_addr = 0x7FF, mem_data_in = 0xA5, mem_core_id = 1, mem_opcode = 3 in the same cycle; back in IDLE the next cycle.
- Single read: core3 reads 0x010, memory returns 0x3C two cycles after the strobe → core_rvalid = 1000, core_rdata = 0x3C, core_err = 0, three cycles after the strobe.
- Round robin: all four cores issue writes continuously → grant order 0,1,2,3,0,1, one grant every 2 cycles.
- Timeout: core0 read, mem_rvalid never asserted → core_rvalid = 0001 with core_err = 1 and core_rdata = 0 at TIMEOUT_CYCLES+1 cycles after the strobe; a later stray mem_rvalid is ignored.
- Tie case: mem_rvalid with data 0x77 arrives exactly on the timeout cycle → core_rdata = 0x77, core_err = 0.
